// File: rtl/zipdma_chsched.sv
// zipdma_chsched: round-robin channel scheduler for a single DMA engine.
// Channels post one-cycle requests. The scheduler latches them as pending,
// grants one channel at a time, hands that channel's descriptor to the
// engine, and reports done or error back to the channel.
// Optional: define ZIPDMA_CHSCHED_WATCHDOG_EN to add a watchdog. When the
// watchdog expires, the active transfer is aborted.
module zipdma_chsched #(
  parameter int NCHAN         = 4,
  parameter int ADDRESS_WIDTH = 30,
  parameter int LGDMALENGTH   = 30,
  parameter int LGWATCHDOG    = 20
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic [NCHAN-1:0]               i_ch_request,
  input  logic [NCHAN-1:0]               i_ch_abort,
  input  logic [NCHAN*ADDRESS_WIDTH-1:0] i_ch_src,
  input  logic [NCHAN*ADDRESS_WIDTH-1:0] i_ch_dst,
  input  logic [NCHAN*LGDMALENGTH-1:0]   i_ch_len,
  output logic [NCHAN-1:0]               o_ch_grant,
  output logic [NCHAN-1:0]               o_ch_done,
  output logic [NCHAN-1:0]               o_ch_err,
  output logic [NCHAN-1:0]               o_ch_pending,
  output logic                           o_dma_request,
  output logic                           o_dma_abort,
  output logic [ADDRESS_WIDTH-1:0]       o_src_addr,
  output logic [ADDRESS_WIDTH-1:0]       o_dst_addr,
  output logic [LGDMALENGTH-1:0]         o_length,
  input  logic                           i_dma_busy,
  input  logic                           i_dma_err
);

  localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RUN, S_DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [NCHAN-1:0]         pending_q, pending_d;
  logic [NCHAN-1:0]         grant_q, grant_d;
  logic [NCHAN-1:0]         done_q, done_d;
  logic [NCHAN-1:0]         err_q, err_d;
  logic [CW-1:0]            last_q, last_d;
  logic [CW-1:0]            active_q, active_d;
  logic                     dma_abort_q, dma_abort_d;
  logic [ADDRESS_WIDTH-1:0] src_q, src_d;
  logic [ADDRESS_WIDTH-1:0] dst_q, dst_d;
  logic [LGDMALENGTH-1:0]   len_q, len_d;

  logic [NCHAN-1:0]         active_mask;
  logic [NCHAN-1:0]         req_eff;
  logic [NCHAN-1:0]         eligible;
  logic                     found;
  logic [CW-1:0]            pick;
  logic                     abort_active;
  logic                     timeout;

  // One-hot mask of the channel that currently owns the engine.
  // The mask is empty while the scheduler is idle.
  always_comb begin
    active_mask = '0;
    if (state_q != S_IDLE) active_mask[active_q] = 1'b1;
  end

  // Requests from the active channel are ignored.
  // A request beats an abort on the same channel in the same cycle.
  // A request arriving in IDLE can be granted at once, without first
  // becoming visible as pending.
  assign req_eff  = i_ch_request & ~active_mask;
  assign eligible = (pending_q & ~(i_ch_abort & ~active_mask)) | req_eff;

  // Round-robin search upward from the channel after the last grant.
  always_comb begin
    logic [CW-1:0] cand;
    found = 1'b0;
    pick  = last_q;
    cand  = last_q;
    for (int unsigned i = 1; i <= NCHAN; i++) begin
      cand = CW'((32'(last_q) + i) % NCHAN);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

`ifdef ZIPDMA_CHSCHED_WATCHDOG_EN
  logic [LGWATCHDOG-1:0] wd_q, wd_d;
  // The count reaches all-ones on the edge where it leaves this value.
  // The abort pulse is registered on that same edge.
  localparam logic [LGWATCHDOG-1:0] WD_LAST = {{(LGWATCHDOG-1){1'b1}}, 1'b0};

  // Watchdog count: held at zero while idle, so it is zero on ISSUE entry.
  // It counts in ISSUE and RUN, and holds in DRAIN.
  always_comb begin
    wd_d = wd_q;
    if (state_q == S_IDLE) wd_d = '0;
    else if (state_q == S_ISSUE || state_q == S_RUN) wd_d = wd_q + 1'b1;
  end

  // Watchdog counter register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) wd_q <= '0;
    else         wd_q <= wd_d;
  end

  assign timeout = (state_q == S_ISSUE || state_q == S_RUN) && (wd_q == WD_LAST);
`else
  logic cfg_unused;
  assign cfg_unused = (LGWATCHDOG > 0);
  assign timeout    = 1'b0;
`endif

  assign abort_active = timeout ||
                        ((|(i_ch_abort & active_mask)) &&
                         (state_q == S_ISSUE || state_q == S_RUN));

  // Next-state logic, status pulses, and descriptor capture.
  always_comb begin
    state_d     = state_q;
    pending_d   = eligible;
    grant_d     = '0;
    done_d      = '0;
    err_d       = '0;
    dma_abort_d = 1'b0;
    last_d      = last_q;
    active_d    = active_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    case (state_q)
      S_IDLE: begin
        if (found && !i_dma_busy) begin
          grant_d[pick]   = 1'b1;
          pending_d[pick] = 1'b0;
          last_d          = pick;
          active_d        = pick;
          src_d           = i_ch_src[int'(pick)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
          dst_d           = i_ch_dst[int'(pick)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
          len_d           = i_ch_len[int'(pick)*LGDMALENGTH +: LGDMALENGTH];
          state_d         = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (abort_active) begin
          dma_abort_d = 1'b1;
          state_d     = S_DRAIN;
        end else if (i_dma_busy) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort_active) begin
          dma_abort_d = 1'b1;
          state_d     = S_DRAIN;
        end else if (!i_dma_busy) begin
          if (i_dma_err) err_d[active_q]  = 1'b1;
          else           done_d[active_q] = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (!i_dma_busy) begin
          err_d[active_q] = 1'b1;
          state_d         = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers. Reset clears everything asynchronously.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      pending_q   <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      err_q       <= '0;
      last_q      <= CW'(NCHAN - 1);
      active_q    <= '0;
      dma_abort_q <= 1'b0;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      err_q       <= err_d;
      last_q      <= last_d;
      active_q    <= active_d;
      dma_abort_q <= dma_abort_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
    end
  end

  assign o_ch_grant    = grant_q;
  assign o_ch_done     = done_q;
  assign o_ch_err      = err_q;
  assign o_ch_pending  = pending_q;
  assign o_dma_request = (state_q == S_ISSUE);
  assign o_dma_abort   = dma_abort_q;
  assign o_src_addr    = src_q;
  assign o_dst_addr    = dst_q;
  assign o_length      = len_q;

endmodule

// File: tb/tb_zipdma_chsched.sv
// Directed testbench for zipdma_chsched (NCHAN=4, LGWATCHDOG=4).
module tb_zipdma_chsched;

  localparam int NCH = 4;
  localparam int AW  = 30;
  localparam int LW  = 30;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    ch_request, ch_abort;
  logic [NCH*AW-1:0] ch_src, ch_dst;
  logic [NCH*LW-1:0] ch_len;
  logic [NCH-1:0]    grant, done, err, pending;
  logic              dma_request, dma_abort;
  logic [AW-1:0]     src_addr, dst_addr;
  logic [LW-1:0]     length;
  logic              dma_busy, dma_err;

  int checks = 0;
  int errors = 0;

  zipdma_chsched #(
    .NCHAN(NCH), .ADDRESS_WIDTH(AW), .LGDMALENGTH(LW), .LGWATCHDOG(4)
  ) dut (
    .i_clk(clk), .i_reset(rst),
    .i_ch_request(ch_request), .i_ch_abort(ch_abort),
    .i_ch_src(ch_src), .i_ch_dst(ch_dst), .i_ch_len(ch_len),
    .o_ch_grant(grant), .o_ch_done(done), .o_ch_err(err), .o_ch_pending(pending),
    .o_dma_request(dma_request), .o_dma_abort(dma_abort),
    .o_src_addr(src_addr), .o_dst_addr(dst_addr), .o_length(length),
    .i_dma_busy(dma_busy), .i_dma_err(dma_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int ch, input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input logic [LW-1:0] l);
    ch_src[ch*AW +: AW] = s;
    ch_dst[ch*AW +: AW] = d;
    ch_len[ch*LW +: LW] = l;
  endtask

  // Entered in ISSUE. Raises busy for 1+n cycles, then drops it with err=e.
  // On return the completion pulse is visible.
  task automatic run_engine(input int n, input logic e);
    dma_busy = 1'b1;
    tick();
    repeat (n) tick();
    dma_busy = 1'b0;
    dma_err  = e;
    tick();
    dma_err  = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (grant !== 4'b0) begin errors++; $display("FAIL reset_grant got %b exp 0000", grant); end
    checks++; if (done !== 4'b0 || err !== 4'b0) begin errors++; $display("FAIL reset_status got done=%b err=%b exp 0", done, err); end
    checks++; if (pending !== 4'b0) begin errors++; $display("FAIL reset_pending got %b exp 0000", pending); end
    checks++; if (dma_request !== 1'b0 || dma_abort !== 1'b0) begin errors++; $display("FAIL reset_dma got req=%b abort=%b exp 0", dma_request, dma_abort); end
    checks++; if (src_addr !== '0 || dst_addr !== '0 || length !== '0) begin errors++; $display("FAIL reset_desc got %h %h %h exp 0", src_addr, dst_addr, length); end
  endtask

  task automatic test_single();
    set_cfg(2, 30'h100, 30'h200, 30'd16);
    ch_request = 4'b0100;
    tick();
    ch_request = 4'b0;
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL single_grant got %b exp 0100", grant); end
    checks++; if (src_addr !== 30'h100 || dst_addr !== 30'h200 || length !== 30'd16) begin errors++; $display("FAIL single_desc got %h %h %h exp 100 200 10", src_addr, dst_addr, length); end
    checks++; if (dma_request !== 1'b1 || pending !== 4'b0) begin errors++; $display("FAIL single_issue got req=%b pend=%b exp 1 0000", dma_request, pending); end
    tick();
    checks++; if (dma_request !== 1'b1 || grant !== 4'b0) begin errors++; $display("FAIL single_hold got req=%b grant=%b exp 1 0000", dma_request, grant); end
    dma_busy = 1'b1;
    tick();
    checks++; if (dma_request !== 1'b0) begin errors++; $display("FAIL single_run_req got %b exp 0", dma_request); end
    tick();
    dma_busy = 1'b0;
    tick();
    checks++; if (done !== 4'b0100 || err !== 4'b0) begin errors++; $display("FAIL single_done got done=%b err=%b exp 0100 0000", done, err); end
    tick();
    checks++; if (done !== 4'b0) begin errors++; $display("FAIL single_done_pulse got %b exp 0000", done); end
  endtask

  task automatic test_abort_active();
    int bad;
    bad = 0;
    set_cfg(1, 30'h300, 30'h400, 30'd8);
    ch_request = 4'b0010;
    tick();
    ch_request = 4'b0;
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL abort_grant got %b exp 0010", grant); end
    dma_busy = 1'b1;
    tick();
    ch_abort = 4'b0010;
    tick();
    ch_abort = 4'b0;
    checks++; if (dma_abort !== 1'b1 || dma_request !== 1'b0) begin errors++; $display("FAIL abort_pulse got abort=%b req=%b exp 1 0", dma_abort, dma_request); end
    tick();
    checks++; if (dma_abort !== 1'b0) begin errors++; $display("FAIL abort_one_cycle got %b exp 0", dma_abort); end
    repeat (4) begin
      tick();
      if (done !== 4'b0 || err !== 4'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL abort_drain_quiet got %0d exp 0", bad); end
    dma_busy = 1'b0;
    tick();
    checks++; if (err !== 4'b0010 || done !== 4'b0) begin errors++; $display("FAIL abort_err got err=%b done=%b exp 0010 0000", err, done); end
  endtask

  task automatic test_round_robin();
    tick();
    ch_request = 4'b1011;
    tick();
    ch_request = 4'b0;
    checks++; if (grant !== 4'b1000 || pending !== 4'b0011) begin errors++; $display("FAIL rr_first got grant=%b pend=%b exp 1000 0011", grant, pending); end
    run_engine(2, 1'b0);
    checks++; if (done !== 4'b1000 || grant !== 4'b0) begin errors++; $display("FAIL rr_done3 got done=%b grant=%b exp 1000 0000", done, grant); end
    tick();
    checks++; if (grant !== 4'b0001 || pending !== 4'b0010) begin errors++; $display("FAIL rr_second got grant=%b pend=%b exp 0001 0010", grant, pending); end
    run_engine(1, 1'b0);
    checks++; if (done !== 4'b0001) begin errors++; $display("FAIL rr_done0 got %b exp 0001", done); end
    tick();
    checks++; if (grant !== 4'b0010 || pending !== 4'b0) begin errors++; $display("FAIL rr_third got grant=%b pend=%b exp 0010 0000", grant, pending); end
    run_engine(0, 1'b0);
    checks++; if (done !== 4'b0010) begin errors++; $display("FAIL rr_done1 got %b exp 0010", done); end
  endtask

  task automatic test_error_and_pending_abort();
    tick();
    ch_request = 4'b0001;
    tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL err_grant got %b exp 0001", grant); end
    ch_request = 4'b0100;
    tick();
    ch_request = 4'b0;
    checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL err_pend got %b exp 0100", pending); end
    ch_abort = 4'b0100;
    tick();
    ch_abort = 4'b0;
    checks++; if (pending !== 4'b0 || err !== 4'b0 || done !== 4'b0 || dma_abort !== 1'b0) begin errors++; $display("FAIL pend_abort got pend=%b err=%b done=%b abort=%b exp all 0", pending, err, done, dma_abort); end
    run_engine(1, 1'b1);
    checks++; if (err !== 4'b0001 || done !== 4'b0) begin errors++; $display("FAIL err_status got err=%b done=%b exp 0001 0000", err, done); end
    tick();
    checks++; if (grant !== 4'b0) begin errors++; $display("FAIL err_no_grant got %b exp 0000", grant); end
  endtask

  task automatic test_req_wins_zero_len();
    set_cfg(3, 30'h500, 30'h600, 30'd0);
    dma_busy   = 1'b1;
    ch_request = 4'b1000;
    ch_abort   = 4'b1000;
    tick();
    ch_request = 4'b0;
    ch_abort   = 4'b0;
    checks++; if (pending !== 4'b1000 || grant !== 4'b0) begin errors++; $display("FAIL req_wins got pend=%b grant=%b exp 1000 0000", pending, grant); end
    dma_busy = 1'b0;
    tick();
    checks++; if (grant !== 4'b1000 || length !== 30'd0 || dma_request !== 1'b1) begin errors++; $display("FAIL zero_len got grant=%b len=%h req=%b exp 1000 0 1", grant, length, dma_request); end
    run_engine(0, 1'b0);
    checks++; if (done !== 4'b1000) begin errors++; $display("FAIL zero_len_done got %b exp 1000", done); end
  endtask

`ifdef ZIPDMA_CHSCHED_WATCHDOG_EN
  task automatic test_watchdog();
    int seen;
    seen = -1;
    tick();
    ch_request = 4'b0010;
    tick();
    ch_request = 4'b0;
    dma_busy   = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (dma_abort === 1'b1 && seen < 0) seen = k;
    end
    checks++; if (seen != 15) begin errors++; $display("FAIL wd_abort_cycle got %0d exp 15", seen); end
    dma_busy = 1'b0;
    tick();
    checks++; if (err !== 4'b0010 || done !== 4'b0) begin errors++; $display("FAIL wd_err got err=%b done=%b exp 0010 0000", err, done); end
  endtask
`else
  task automatic test_no_watchdog();
    int aborts;
    aborts = 0;
    tick();
    ch_request = 4'b0010;
    tick();
    ch_request = 4'b0;
    dma_busy   = 1'b1;
    repeat (1000) begin
      tick();
      if (dma_abort !== 1'b0 || err !== 4'b0) aborts++;
    end
    checks++; if (aborts != 0) begin errors++; $display("FAIL nowd_abort got %0d exp 0", aborts); end
    dma_busy = 1'b0;
    tick();
    checks++; if (done !== 4'b0010) begin errors++; $display("FAIL nowd_done got %b exp 0010", done); end
  endtask
`endif

  task automatic test_reset_mid_run();
    int bad;
    bad = 0;
    set_cfg(0, 30'h700, 30'h800, 30'd4);
    tick();
    ch_request = 4'b0001;
    tick();
    ch_request = 4'b0;
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rst_grant got %b exp 0001", grant); end
    dma_busy   = 1'b1;
    ch_request = 4'b0100;
    tick();
    ch_request = 4'b0;
    checks++; if (pending !== 4'b0100 || src_addr !== 30'h700) begin errors++; $display("FAIL rst_pre got pend=%b src=%h exp 0100 700", pending, src_addr); end
    #2 rst = 1'b1;
    #1;
    checks++; if (pending !== 4'b0 || src_addr !== '0 || dst_addr !== '0 || length !== '0 || dma_request !== 1'b0 || dma_abort !== 1'b0) begin errors++; $display("FAIL rst_async got pend=%b src=%h req=%b exp 0", pending, src_addr, dma_request); end
    tick();
    rst      = 1'b0;
    dma_busy = 1'b0;
    repeat (5) begin
      tick();
      if (done !== 4'b0 || err !== 4'b0 || grant !== 4'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rst_no_pulse got %0d exp 0", bad); end
  endtask

  initial begin
    rst        = 1'b1;
    ch_request = '0;
    ch_abort   = '0;
    ch_src     = '0;
    ch_dst     = '0;
    ch_len     = '0;
    dma_busy   = 1'b0;
    dma_err    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_single();
    test_abort_active();
    test_round_robin();
    test_error_and_pending_abort();
    test_req_wins_zero_len();
`ifdef ZIPDMA_CHSCHED_WATCHDOG_EN
    test_watchdog();
`else
    test_no_watchdog();
`endif
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
